// File: rtl/fm_freq_decim.sv
// fm_freq_decim
// Turns the CORDIC vectoring phase stream into a decimated instantaneous
// frequency stream. A wrap-correct phase difference is taken per sample,
// gated by a magnitude squelch, then integrated and dumped over dec_n
// samples into one saturated output word per frame.
//
// Ports
//   clk_in      : single clock, rising edge
//   RST         : asynchronous active-low reset
//   dec_n       : samples per output frame (0 behaves as 1), latched at frame start
//   squelch_th  : unsigned magnitude threshold
//   phase_valid : qualifies phase_in / mag_in
//   phase_in    : signed phase, full scale = 2*pi
//   mag_in      : unsigned magnitude, same timing as phase_in
//   freq_out    : signed decimated frequency, holds between updates
//   freq_valid  : one-cycle pulse per new freq_out
//   squelched   : most recent accepted sample was below threshold
//
// State table
//   state       | meaning
//   ST_UNPRIMED | no usable previous phase; next accepted sample yields diff 0
//   ST_PRIMED   | phase_prev is valid; diffs are real
module fm_freq_decim #(
    parameter int PH_WIDTH  = 24,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 8
) (
    input  logic                 clk_in,
    input  logic                 RST,
    input  logic [15:0]          dec_n,
    input  logic [PH_WIDTH-1:0]  squelch_th,
    input  logic                 phase_valid,
    input  logic [PH_WIDTH-1:0]  phase_in,
    input  logic [PH_WIDTH-1:0]  mag_in,
    output logic [OUT_WIDTH-1:0] freq_out,
    output logic                 freq_valid,
    output logic                 squelched
);

    localparam logic [0:0] ST_UNPRIMED = 1'b0;
    localparam logic [0:0] ST_PRIMED   = 1'b1;

    // 16 guard bits cover any 16-bit frame length without overflow.
    localparam int ACC_W = PH_WIDTH + 16;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [0:0]                 state;
    logic [PH_WIDTH-1:0]        phase_prev;
    logic signed [PH_WIDTH-1:0] diff_r;
    logic                       diff_v;

    logic signed [ACC_W-1:0]    acc;
    logic [15:0]                cnt;
    logic [15:0]                n_lat;

    logic signed [ACC_W-1:0]    diff_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    shifted;
    logic [OUT_WIDTH-1:0]       sat_val;
    logic [15:0]                n_eff;
    logic                       frame_last;

    // Stage 1: squelch qualification and modulo-2pi phase difference.
    // The subtraction simply wraps at PH_WIDTH bits, which is exactly the
    // modulo-2pi difference read as signed.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            state      <= ST_UNPRIMED;
            phase_prev <= '0;
            diff_r     <= '0;
            diff_v     <= 1'b0;
            squelched  <= 1'b0;
        end else begin
            diff_v <= phase_valid;
            if (phase_valid) begin
                phase_prev <= phase_in;
                if (mag_in < squelch_th) begin
                    diff_r    <= '0;
                    squelched <= 1'b1;
                    state     <= ST_UNPRIMED;
                end else if (state == ST_UNPRIMED) begin
                    diff_r    <= '0;
                    squelched <= 1'b0;
                    state     <= ST_PRIMED;
                end else begin
                    diff_r    <= phase_in - phase_prev;
                    squelched <= 1'b0;
                end
            end
        end
    end

    // Stage 2 datapath: a frame start restarts the sum and relatches the
    // frame length, so dec_n edits never disturb a frame in progress.
    always_comb begin
        diff_ext = {{16{diff_r[PH_WIDTH-1]}}, diff_r};
        if (cnt == 16'd0) begin
            n_eff = (dec_n == 16'd0) ? 16'd1 : dec_n;
            sum   = diff_ext;
        end else begin
            n_eff = n_lat;
            sum   = acc + diff_ext;
        end
        frame_last = (cnt == n_eff - 16'd1);
        shifted    = sum >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat_val = shifted[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            acc        <= '0;
            cnt        <= '0;
            n_lat      <= 16'd1;
            freq_out   <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (diff_v) begin
                acc <= sum;
                if (cnt == 16'd0) begin
                    n_lat <= n_eff;
                end
                if (frame_last) begin
                    freq_out   <= sat_val;
                    freq_valid <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/fm_freq_decim.md
# fm_freq_decim

Post-demodulation stage that turns the CORDIC vectoring phase stream (PM output, at the I/Q mixer's decimated rate) into a decimated instantaneous-frequency (FM audio) stream. Per input sample it computes the modulo-2π phase difference. A magnitude squelch driven by the CORDIC magnitude (AM output) gates that difference. An integrate-and-dump over a runtime-programmable number of samples then produces one saturated output word per frame. It sits directly downstream of the demodulator and replaces the unsynchronized, unwrapped single-register phase difference with a qualified, wrap-correct, decimated one.

## Interface
- PH_WIDTH, 24, width of phase_in/mag_in/squelch_th; phase full scale 2^PH_WIDTH = 2π, two's complement
- OUT_WIDTH, 16, width of freq_out (signed)
- OUT_SHIFT, 8, arithmetic right shift applied to the frame sum before saturation (0..PH_WIDTH+15)
- clk_in  in  1  single clock; all logic on rising edge
- RST  in  1  asynchronous, active-low reset (asserts immediately, deasserted synchronously by the integrator of this block)
- dec_n  in  16  decimation ratio, samples per output; 0 treated as 1
- squelch_th  in  PH_WIDTH  unsigned magnitude threshold
- phase_valid  in  1  qualifies phase_in/mag_in for one cycle
- phase_in  in  PH_WIDTH  signed phase sample
- mag_in  in  PH_WIDTH  unsigned magnitude sample, same timing as phase_in
- freq_out  out  OUT_WIDTH  signed decimated frequency; holds between updates
- freq_valid  out  1  one-cycle pulse per new freq_out
- squelched  out  1  high while the most recent accepted sample was below threshold

## Operation
- State: UNPRIMED (no valid previous phase) / PRIMED. Reset → UNPRIMED.
- Stage 1 (on phase_valid):
  - If mag_in < squelch_th: diff_r = 0, squelched = 1, state → UNPRIMED.
  - Else if UNPRIMED: diff_r = 0, squelched = 0, state → PRIMED.
  - Else: diff_r = (phase_in − phase_prev) mod 2^PH_WIDTH, read as signed (natural wrap; +π→−π crossings give small diffs), squelched = 0.
  - phase_prev ← phase_in always; diff_v ← 1. Otherwise diff_v ← 0, and phase_prev, state and squelched hold.
- Stage 2 (on diff_v):
  - Accumulator is signed, PH_WIDTH+16 bits; no overflow possible.
  - cnt == 0: n_lat ← max(dec_n,1) and sum = diff_r; otherwise sum = acc + diff_r. acc ← sum.
  - cnt == n_lat−1: freq_out ← sat(sum >>> OUT_SHIFT), freq_valid ← 1, cnt ← 0. Otherwise cnt ← cnt+1.
  - sat() clamps to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. Shift is floor (arithmetic) with no rounding.
- dec_n changes take effect only at the next frame start. Squelched and priming samples count toward the frame as zeros.

## Timing
- Reset values: freq_out = 0, freq_valid = 0, squelched = 0, diff_v = 0, acc = 0, cnt = 0, phase_prev = 0, state UNPRIMED.
- Latency: phase_valid sampled at edge k → freq_valid high for the cycle after edge k+1 (2 edges), when that sample closes a frame.
- phase_valid may be high every cycle; no backpressure. Back-to-back frames with n_lat = 1 give freq_valid every cycle.
- Reset mid-frame discards the partial sum. The first frame after reset starts with a zero diff (priming).
- Squelch is evaluated per sample. The sample following a squelched one is a priming sample (diff 0) even if above threshold.

## Test plan
- Ramp: dec_n=4, OUT_SHIFT=2, squelch_th=0, phase_in += 0x001000 per valid for 9 samples. Expected: freq_out = 3072 (first frame, includes priming zero), then 4096; freq_valid exactly 2 pulses, each 2 edges after the 4th/8th valid.
- Wrap: dec_n=1, OUT_SHIFT=0, phase 0x7FF000 then 0x800800. Expected: second output = +6144 (0x1800), not a large negative value. Reverse order gives −6144.
- Squelch: squelch_th=0x000100, mag_in=0x0000FF on sample 3 of a ramp. Expected: squelched=1; samples 3 and 4 contribute 0; squelched returns to 0 on sample 4.
- Saturation: OUT_WIDTH=16, OUT_SHIFT=0, dec_n=4, diffs +0x100000 → 32767; diffs −0x100000 → −32768.
- dec_n=0 → one output per valid. Change dec_n 4→2 mid-frame: current frame still closes after 4 samples, then frames of 2.
- RST low mid-frame (cnt=2): all outputs return to reset values immediately. After release, the next frame starts at cnt=0 with a priming zero.
